// File: rtl/hazard_unit_if.sv
// Hazard-control signal bundle: pipeline-side hazard inputs plus the stall/flush controls and counters.
interface hazard_unit_if;
   logic        ctrl_memRead_id_ex;
   logic [4:0]  next_instruction_20_16_id_ex;
   logic [4:0]  instruction_25_21_if_id;
   logic [4:0]  instruction_20_16_if_id;
   logic        branch_taken;
   logic        mem_busy;
   logic        pc_write;
   logic        if_id_write;
   logic        id_ex_bubble;
   logic        if_id_flush;
   logic        pipe_freeze;
   logic [15:0] stall_cycles;
   logic [15:0] flush_events;

   modport master (
      output ctrl_memRead_id_ex, next_instruction_20_16_id_ex,
             instruction_25_21_if_id, instruction_20_16_if_id,
             branch_taken, mem_busy,
      input  pc_write, if_id_write, id_ex_bubble, if_id_flush, pipe_freeze,
             stall_cycles, flush_events
   );

   modport slave (
      input  ctrl_memRead_id_ex, next_instruction_20_16_id_ex,
             instruction_25_21_if_id, instruction_20_16_if_id,
             branch_taken, mem_busy,
      output pc_write, if_id_write, id_ex_bubble, if_id_flush, pipe_freeze,
             stall_cycles, flush_events
   );
endinterface

// File: rtl/hazard_unit.sv
// Load-use / branch-flush / memory-stall control; controls are combinational (0-cycle) from state and inputs.
// mem_busy freezes the whole pipeline and holds the sequencer; counters update on the clock edge.
module hazard_unit (
   input logic           clk,
   input logic           reset,
   hazard_unit_if.slave  hz
);
   typedef enum logic [1:0] {RUN, BUBBLE, FLUSH2} state_t;

   state_t      state_q, state_d;
   logic [15:0] stall_q, stall_d;
   logic [15:0] flush_q, flush_d;

   logic load_use;
   logic pc_write, if_id_write, id_ex_bubble, if_id_flush, pipe_freeze;

   // rt_ex == 0 is register zero and can never carry a real dependency.
   assign load_use = hz.ctrl_memRead_id_ex
                   && (hz.next_instruction_20_16_id_ex != 5'd0)
                   && ((hz.next_instruction_20_16_id_ex == hz.instruction_25_21_if_id)
                    || (hz.next_instruction_20_16_id_ex == hz.instruction_20_16_if_id));

   always_comb begin
      state_d      = state_q;
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      id_ex_bubble = 1'b0;
      if_id_flush  = 1'b0;
      pipe_freeze  = 1'b0;
      if (reset) begin
         state_d = RUN;
      end else if (hz.mem_busy) begin
         pc_write    = 1'b0;
         if_id_write = 1'b0;
         pipe_freeze = 1'b1;
      end else begin
         case (state_q)
            RUN: begin
               if (hz.branch_taken) begin
                  if_id_flush  = 1'b1;
                  id_ex_bubble = 1'b1;
                  state_d      = FLUSH2;
               end else if (load_use) begin
                  pc_write     = 1'b0;
                  if_id_write  = 1'b0;
                  id_ex_bubble = 1'b1;
                  state_d      = BUBBLE;
               end
            end
            BUBBLE: state_d = RUN;
            FLUSH2: begin
               // The redirected PC lands now; the wrong-path fetch still needs squashing.
               if_id_flush = 1'b1;
               state_d     = RUN;
            end
            default: state_d = RUN;
         endcase
      end
   end

   always_comb begin
      stall_d = stall_q;
      flush_d = flush_q;
      if (!pc_write && (stall_q != 16'hFFFF))
         stall_d = stall_q + 16'd1;
      if ((state_q == RUN) && (state_d == FLUSH2) && (flush_q != 16'hFFFF))
         flush_d = flush_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= RUN;
         stall_q <= 16'd0;
         flush_q <= 16'd0;
      end else begin
         state_q <= state_d;
         stall_q <= stall_d;
         flush_q <= flush_d;
      end
   end

   assign hz.pc_write     = pc_write;
   assign hz.if_id_write  = if_id_write;
   assign hz.id_ex_bubble = id_ex_bubble;
   assign hz.if_id_flush  = if_id_flush;
   assign hz.pipe_freeze  = pipe_freeze;
   assign hz.stall_cycles = stall_q;
   assign hz.flush_events = flush_q;
endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: directed hazard scenarios, randomized traffic and counter saturation.
module tb_hazard_unit;
   logic clk;
   logic reset;
   int   errs;
   int   checks;

   // Reference model: pending obligations rather than pipeline states.
   bit   m_redirect;
   bit   m_bubble_done;
   int   m_stall;
   int   m_flush;
   logic [4:0] obs_ctrl;

   hazard_unit_if hz ();

   hazard_unit dut (
      .clk   (clk),
      .reset (reset),
      .hz    (hz)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int sat_inc(input int v);
      return (v >= 65535) ? 65535 : v + 1;
   endfunction

   // One clock: apply inputs, compare controls ({pc,ifid,bubble,flush,freeze}), then counters after the edge.
   task automatic step(input bit r, input bit mr, input bit [4:0] rte, input bit [4:0] rsi,
                       input bit [4:0] rti, input bit br, input bit mb);
      bit       lu;
      bit [4:0] exp;
      reset                           = r;
      hz.ctrl_memRead_id_ex           = mr;
      hz.next_instruction_20_16_id_ex = rte;
      hz.instruction_25_21_if_id      = rsi;
      hz.instruction_20_16_if_id      = rti;
      hz.branch_taken                 = br;
      hz.mem_busy                     = mb;
      #1;
      lu = mr && (rte != 0) && ((rte == rsi) || (rte == rti));
      if (r)                  exp = 5'b11000;
      else if (mb)            exp = 5'b00001;
      else if (m_redirect)    begin exp = 5'b11010; m_redirect = 0; end
      else if (m_bubble_done) begin exp = 5'b11000; m_bubble_done = 0; end
      else if (br)            begin exp = 5'b11110; m_redirect = 1; m_flush = sat_inc(m_flush); end
      else if (lu)            begin exp = 5'b00100; m_bubble_done = 1; end
      else                    exp = 5'b11000;
      if (r) begin
         m_redirect = 0; m_bubble_done = 0; m_stall = 0; m_flush = 0;
      end else if (!exp[4]) begin
         m_stall = sat_inc(m_stall);
      end
      obs_ctrl = {hz.pc_write, hz.if_id_write, hz.id_ex_bubble, hz.if_id_flush, hz.pipe_freeze};
      chk("ctrl", 32'(obs_ctrl), 32'(exp));
      @(posedge clk);
      #1;
      chk("stall_cnt", 32'(hz.stall_cycles), 32'(m_stall));
      chk("flush_cnt", 32'(hz.flush_events), 32'(m_flush));
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      errs = 0; checks = 0;
      m_redirect = 0; m_bubble_done = 0; m_stall = 0; m_flush = 0;

      // Reset with every event asserted: defaults must win.
      step(1, 1, 5, 5, 5, 1, 1);
      chk("rst_ctrl", 32'(obs_ctrl), 32'(5'b11000));
      step(1, 0, 0, 0, 0, 0, 0);
      chk("rst_stall", 32'(hz.stall_cycles), 32'd0);

      // Load-use: exactly one bubble even though the hazard persists.
      step(0, 1, 5, 5, 9, 0, 0);
      chk("lu_ctrl", 32'(obs_ctrl), 32'(5'b00100));
      chk("lu_stall", 32'(hz.stall_cycles), 32'd1);
      step(0, 1, 5, 5, 9, 0, 0);
      chk("lu_after", 32'(obs_ctrl), 32'(5'b11000));

      // Register zero never forms a hazard.
      step(0, 1, 0, 0, 0, 0, 0);
      chk("rt0_ctrl", 32'(obs_ctrl), 32'(5'b11000));
      chk("rt0_stall", 32'(hz.stall_cycles), 32'd1);

      // Branch and load-use together: the flush wins.
      step(1, 0, 0, 0, 0, 0, 0);
      step(0, 1, 7, 3, 7, 1, 0);
      chk("br_c1", 32'(obs_ctrl), 32'(5'b11110));
      step(0, 1, 7, 3, 7, 1, 0);
      chk("br_c2", 32'(obs_ctrl), 32'(5'b11010));
      chk("br_flush", 32'(hz.flush_events), 32'd1);
      chk("br_stall", 32'(hz.stall_cycles), 32'd0);

      // mem_busy for three cycles during FLUSH2 holds the redirect.
      step(1, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 1, 0);
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 0, 0, 0, 1, 1);
         chk("busy_ctrl", 32'(obs_ctrl), 32'(5'b00001));
      end
      step(0, 0, 0, 0, 0, 1, 0);
      chk("busy_f2", 32'(obs_ctrl), 32'(5'b11010));
      chk("busy_stall", 32'(hz.stall_cycles), 32'd3);
      step(0, 0, 0, 0, 0, 0, 0);
      chk("busy_run", 32'(obs_ctrl), 32'(5'b11000));

      // Reset while in BUBBLE.
      step(0, 1, 4, 1, 4, 0, 0);
      step(1, 1, 4, 1, 4, 0, 0);
      chk("rstb_ctrl", 32'(obs_ctrl), 32'(5'b11000));
      chk("rstb_stall", 32'(hz.stall_cycles), 32'd0);
      chk("rstb_flush", 32'(hz.flush_events), 32'd0);
      step(0, 0, 0, 0, 0, 0, 0);
      chk("rstb_run", 32'(obs_ctrl), 32'(5'b11000));

      // Randomized traffic with small register numbers to provoke hazards.
      for (int i = 0; i < 600; i++) begin
         step(($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)),
              5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0));
      end

      // Saturation of stall_cycles.
      step(1, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 65536; i++) step(0, 0, 0, 0, 0, 0, 1);
      chk("stall_sat", 32'(hz.stall_cycles), 32'h0000FFFF);
      step(0, 0, 0, 0, 0, 0, 0);
      chk("stall_hold", 32'(hz.stall_cycles), 32'h0000FFFF);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 SHALL be single clock, single reset: one clock; reset is synchronous and active-high.
REQ-002 SHALL have ports: clk  in  1  rising-edge clock.
REQ-003 SHALL have ports: reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have ports: ctrl_memRead_id_ex  in  1  instruction in EX is a load.
REQ-005 SHALL have ports: next_instruction_20_16_id_ex  in  5  rt of instruction in EX.
REQ-006 SHALL have ports: instruction_25_21_if_id, instruction_20_16_if_id  in  5 each  rs/rt of instruction in ID.
REQ-007 SHALL have ports: branch_taken  in  1  branch in EX resolved taken.
REQ-008 SHALL have ports: mem_busy  in  1  data memory not ready; whole pipeline must hold.
REQ-009 SHALL have ports: pc_write, if_id_write  out  1 each  enable PC / IF-ID update.
REQ-010 SHALL have ports: id_ex_bubble  out  1  zero ID/EX control fields at next edge.
REQ-011 SHALL have ports: if_id_flush  out  1  replace IF/ID contents with NOP at next edge.
REQ-012 SHALL have ports: pipe_freeze  out  1  hold ID/EX, EX/MEM, MEM/WB.
REQ-013 SHALL have ports: stall_cycles, flush_events  out  16 each  saturating performance counters.

Function
REQ-014 SHALL implement FSM states RUN, BUBBLE, FLUSH2; control outputs combinational from state and current inputs.
REQ-015 SHALL define load_use = ctrl_memRead_id_ex & (rt_ex != 0) & (rt_ex == rs_id | rt_ex == rt_id).
REQ-016 SHALL apply priority mem_busy > branch_taken > load_use.
REQ-017 SHALL, whenever mem_busy=1 (any state): pc_write=0, if_id_write=0, pipe_freeze=1, id_ex_bubble=0, if_id_flush=0, state held.
REQ-018 SHALL, in RUN with branch_taken=1: if_id_flush=1, id_ex_bubble=1, pc_write=1, if_id_write=1; next state FLUSH2.
REQ-019 SHALL, in FLUSH2 (PC redirect lands this cycle): if_id_flush=1, id_ex_bubble=0, pc_write=1; next state RUN; branch_taken and load_use ignored.
REQ-020 SHALL, in RUN with load_use=1 and no branch_taken: pc_write=0, if_id_write=0, id_ex_bubble=1; next state BUBBLE.
REQ-021 SHALL, in BUBBLE: all control outputs at default; load_use and branch_taken ignored; next state RUN (exactly one bubble per load).
REQ-022 SHALL, by default (RUN, no event): pc_write=1, if_id_write=1, others 0; next state RUN.
REQ-023 SHALL increment stall_cycles by 1 every clock with pc_write=0; saturate at 16'hFFFF.
REQ-024 SHALL increment flush_events by 1 on each RUN->FLUSH2 transition; saturate at 16'hFFFF.
REQ-025 SHALL treat rt_ex=0 as no hazard regardless of ID register numbers.

Reset
REQ-026 SHALL, on clk edge with reset=1: state=RUN, stall_cycles=0, flush_events=0.
REQ-027 SHALL drive default outputs (pc_write=1, if_id_write=1, others 0) in any cycle where reset=1, overriding mem_busy and all events.
REQ-028 SHALL abandon BUBBLE/FLUSH2 on reset mid-sequence; first post-reset cycle evaluates from RUN.

Verification
REQ-029 SHALL cover load-use: memRead=1, rt_ex=5, rs_id=5 -> one cycle pc_write=0, id_ex_bubble=1, stall_cycles=1; next cycle defaults even if inputs unchanged.
REQ-030 SHALL cover rt_ex=0 with memRead=1, rs_id=0 -> no stall, counters unchanged.
REQ-031 SHALL cover branch_taken=1 together with load_use=1 in RUN -> flush wins: if_id_flush=1 two cycles, id_ex_bubble=1 first cycle only, flush_events=1, stall_cycles=0.
REQ-032 SHALL cover mem_busy=1 for 3 cycles during FLUSH2 -> pipe_freeze=1 and pc_write=0 for 3 cycles, state held, then one FLUSH2 cycle, stall_cycles=3.
REQ-033 SHALL cover saturation: preload via 65535 stall cycles then one more -> stall_cycles stays 16'hFFFF.
REQ-034 SHALL cover reset asserted in BUBBLE -> next cycle RUN, counters 0, defaults driven.
